// File: rtl/mem_load_unit_pkg.sv
// Encodings shared by the load and store paths: access class, access size and controller state codes.
package mem_load_unit_pkg;

    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [1:0] MEM_BYTE  = 2'b00;
    localparam logic [1:0] MEM_HALF  = 2'b01;
    localparam logic [1:0] MEM_WORD  = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Size 2'b11 behaves as a word, so it shares the word alignment rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return offset[0];
            default:  return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_unit_align.sv
// Little-endian lane select and sign/zero extension of one SRAM word.
module load_align
    import mem_load_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[7:0];
        case (offset)
            2'd0: byte_lane = word[7:0];
            2'd1: byte_lane = word[15:8];
            2'd2: byte_lane = word[23:16];
            2'd3: byte_lane = word[31:24];
            default: byte_lane = word[7:0];
        endcase
        half_lane = offset[1] ? word[31:16] : word[15:0];

        result = word;
        case (size)
            MEM_BYTE: result = {{24{~uns & byte_lane[7]}}, byte_lane};
            MEM_HALF: result = {{16{~uns & half_lane[15]}}, half_lane};
            default:  result = word;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// Load path controller: issues one SRAM read per accepted load and holds the aligned result until writeback takes it.
// Optional MEM_MISALIGN_CHECK_EN answers misaligned half/word loads with a flagged zero result instead of reading.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request; an accepted load strobes the SRAM here
// ST_WAIT | read in flight, down-counter runs to terminal count
// ST_RESP | result valid, held until load_ready
module mem_load_unit
    import mem_load_unit_pkg::*;
#(
    parameter int READ_LAT = 1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  mem_op,
    input  logic [31:0] addr,
    output logic [13:0] sram_addr,
    output logic        sram_oe,
    input  logic [31:0] sram_dout,
    output logic        load_valid,
    input  logic        load_ready,
    output logic [31:0] load_data,
    output logic        load_misalign
);

    localparam logic [1:0] LAT_TC = 2'(READ_LAT - 1);

    logic [1:0]  state_q;
    logic [1:0]  cnt_q;
    logic [13:0] addr_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] data_q;
    logic [31:0] aligned;
    logic        accept;
    logic        mis_now;
    logic        unused_addr;

    assign unused_addr = ^addr[31:14];

    // Gating with rst_n keeps the strobe and handshake quiet while reset is held.
    assign req_ready  = rst_n && (state_q == ST_IDLE);
    assign accept     = req_valid && req_ready && (mem_op[4:3] == MEM_READ);
    assign sram_oe    = accept && !mis_now;
    assign sram_addr  = accept ? addr[13:0] : addr_q;
    assign load_valid = (state_q == ST_RESP);
    assign load_data  = data_q;

`ifdef MEM_MISALIGN_CHECK_EN
    logic mis_q;

    assign mis_now       = is_misaligned(mem_op[1:0], addr[1:0]);
    assign load_misalign = mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= mis_now;
        end else if (load_valid && load_ready) begin
            mis_q <= 1'b0;
        end
    end
`else
    assign mis_now       = 1'b0;
    assign load_misalign = 1'b0;
`endif

    load_align u_align (
        .word   (sram_dout),
        .offset (off_q),
        .size   (size_q),
        .uns    (uns_q),
        .result (aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= 14'd0;
            off_q   <= 2'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q <= addr[13:0];
                        off_q  <= addr[1:0];
                        size_q <= mem_op[1:0];
                        uns_q  <= mem_op[2];
                        cnt_q  <= LAT_TC;
                        if (mis_now) begin
                            data_q  <= 32'd0;
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 2'd0) begin
                        data_q  <= aligned;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ST_RESP: begin
                    if (load_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// Self-checking bench: one unit with READ_LAT=1 and one with READ_LAT=3, each fed by a latency-accurate SRAM model.
module tb_mem_load_unit;
    import mem_load_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid     [2];
    logic [4:0]  mem_op        [2];
    logic [31:0] addr          [2];
    logic        load_ready    [2];
    logic        req_ready     [2];
    logic        sram_oe       [2];
    logic [13:0] sram_addr     [2];
    logic [31:0] sram_dout     [2];
    logic        load_valid    [2];
    logic [31:0] load_data     [2];
    logic        load_misalign [2];
    logic [31:0] mem_word      [2];
    logic [2:0]  oe_pipe       [2];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_load_unit #(.READ_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .mem_op(mem_op[0]), .addr(addr[0]), .sram_addr(sram_addr[0]), .sram_oe(sram_oe[0]),
        .sram_dout(sram_dout[0]), .load_valid(load_valid[0]), .load_ready(load_ready[0]),
        .load_data(load_data[0]), .load_misalign(load_misalign[0])
    );

    mem_load_unit #(.READ_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .mem_op(mem_op[1]), .addr(addr[1]), .sram_addr(sram_addr[1]), .sram_oe(sram_oe[1]),
        .sram_dout(sram_dout[1]), .load_valid(load_valid[1]), .load_ready(load_ready[1]),
        .load_data(load_data[1]), .load_misalign(load_misalign[1])
    );

    // Read data is only valid exactly READ_LAT cycles after the strobe; garbage otherwise.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_pipe[0] <= 3'b000;
            oe_pipe[1] <= 3'b000;
        end else begin
            oe_pipe[0] <= {oe_pipe[0][1:0], sram_oe[0]};
            oe_pipe[1] <= {oe_pipe[1][1:0], sram_oe[1]};
        end
    end
    assign sram_dout[0] = oe_pipe[0][0] ? mem_word[0] : 32'hDEAD_BEEF;
    assign sram_dout[1] = oe_pipe[1][2] ? mem_word[1] : 32'hDEAD_BEEF;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] dout;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] mk_op(input logic [1:0] cls, input logic uns, input logic [1:0] size);
        return {cls, uns, size};
    endfunction

    function automatic vec_t mk_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] dout,
                                    input logic [31:0] exp_data, input logic exp_mis);
        vec_t v;
        v.op = op; v.a = a; v.dout = dout; v.exp_data = exp_data; v.exp_mis = exp_mis;
        return v;
    endfunction

    // Entered and left at a falling edge.
    task automatic do_load(input int d, input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] dout, input logic [31:0] exp_data, input logic exp_mis,
                           input int hold);
        int lat;
        int exp_lat;
        exp_lat = exp_mis ? 1 : ((d == 0) ? 2 : 4);
        mem_word[d]  = dout;
        req_valid[d] = 1'b1;
        mem_op[d]    = op;
        addr[d]      = a;
        #1;
        chk($sformatf("%s accept_req_ready", tag), 32'(req_ready[d]), 32'd1);
        chk($sformatf("%s accept_sram_oe", tag), 32'(sram_oe[d]), 32'(!exp_mis));
        if (!exp_mis) chk($sformatf("%s accept_sram_addr", tag), 32'(sram_addr[d]), 32'(a[13:0]));
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        mem_op[d]    = 5'd0;
        addr[d]      = ~a;
        lat = 1;
        @(negedge clk);
        while (!load_valid[d] && lat < 10) begin
            chk($sformatf("%s wait_sram_oe", tag), 32'(sram_oe[d]), 32'd0);
            chk($sformatf("%s wait_sram_addr", tag), 32'(sram_addr[d]), 32'(a[13:0]));
            @(posedge clk); #1;
            lat++;
            @(negedge clk);
        end
        chk($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
        for (int k = 0; k < hold; k++) begin
            chk($sformatf("%s hold_valid", tag), 32'(load_valid[d]), 32'd1);
            chk($sformatf("%s hold_data", tag), load_data[d], exp_data);
            chk($sformatf("%s hold_req_ready", tag), 32'(req_ready[d]), 32'd0);
            @(negedge clk);
        end
        load_ready[d] = 1'b1;
        #1;
        chk($sformatf("%s resp_valid", tag), 32'(load_valid[d]), 32'd1);
        chk($sformatf("%s resp_data", tag), load_data[d], exp_data);
        chk($sformatf("%s resp_misalign", tag), 32'(load_misalign[d]), 32'(exp_mis));
        chk($sformatf("%s retire_req_ready", tag), 32'(req_ready[d]), 32'd0);
        @(posedge clk); #1;
        load_ready[d] = 1'b0;
        @(negedge clk);
        chk($sformatf("%s after_valid", tag), 32'(load_valid[d]), 32'd0);
        chk($sformatf("%s after_req_ready", tag), 32'(req_ready[d]), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s[%0d] req_ready", tag, d), 32'(req_ready[d]), 32'd0);
            chk($sformatf("%s[%0d] sram_oe", tag, d), 32'(sram_oe[d]), 32'd0);
            chk($sformatf("%s[%0d] sram_addr", tag, d), 32'(sram_addr[d]), 32'd0);
            chk($sformatf("%s[%0d] load_valid", tag, d), 32'(load_valid[d]), 32'd0);
            chk($sformatf("%s[%0d] load_data", tag, d), load_data[d], 32'd0);
            chk($sformatf("%s[%0d] load_misalign", tag, d), 32'(load_misalign[d]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; mem_op[d] = 5'd0; addr[d] = 32'd0;
            load_ready[d] = 1'b0; mem_word[d] = 32'd0;
        end

        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b0, MEM_BYTE), 32'h0000_0003, 32'h80AB_CDEF, 32'hFFFF_FF80, 1'b0));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b1, MEM_HALF), 32'h0000_0002, 32'h80AB_CDEF, 32'h0000_80AB, 1'b0));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b0, MEM_HALF), 32'h0000_0002, 32'h80AB_CDEF, 32'hFFFF_80AB, 1'b0));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b1, MEM_BYTE), 32'h0000_1230, 32'h80AB_CDEF, 32'h0000_00EF, 1'b0));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b0, MEM_BYTE), 32'h0000_0001, 32'h80AB_CDEF, 32'hFFFF_FFCD, 1'b0));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b1, MEM_BYTE), 32'h0001_2342, 32'h80AB_CDEF, 32'h0000_00AB, 1'b0));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b0, MEM_HALF), 32'h0000_0000, 32'h80AB_CDEF, 32'hFFFF_CDEF, 1'b0));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b1, MEM_HALF), 32'h0000_0000, 32'h80AB_CDEF, 32'h0000_CDEF, 1'b0));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b0, MEM_WORD), 32'h0000_0004, 32'h80AB_CDEF, 32'h80AB_CDEF, 1'b0));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b1, 2'b11),    32'h0000_0008, 32'h80AB_CDEF, 32'h80AB_CDEF, 1'b0));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b0, MEM_BYTE), 32'h0000_0003, 32'h7F01_2345, 32'h0000_007F, 1'b0));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b0, MEM_HALF), 32'h0000_0002, 32'h7F01_2345, 32'h0000_7F01, 1'b0));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b0, MEM_BYTE), 32'h0000_0002, 32'h7F01_2345, 32'h0000_0001, 1'b0));
`ifdef MEM_MISALIGN_CHECK_EN
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b0, MEM_HALF), 32'h0000_0001, 32'h80AB_CDEF, 32'h0000_0000, 1'b1));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b0, MEM_WORD), 32'h0000_0002, 32'h80AB_CDEF, 32'h0000_0000, 1'b1));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b1, MEM_HALF), 32'h0000_0003, 32'h80AB_CDEF, 32'h0000_0000, 1'b1));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b0, 2'b11),    32'h0000_0001, 32'h80AB_CDEF, 32'h0000_0000, 1'b1));
`else
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b0, MEM_HALF), 32'h0000_0001, 32'h80AB_CDEF, 32'hFFFF_CDEF, 1'b0));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b0, MEM_WORD), 32'h0000_0002, 32'h80AB_CDEF, 32'h80AB_CDEF, 1'b0));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b1, MEM_HALF), 32'h0000_0003, 32'h80AB_CDEF, 32'h0000_80AB, 1'b0));
        vecs.push_back(mk_vec(mk_op(MEM_READ, 1'b0, 2'b11),    32'h0000_0001, 32'h80AB_CDEF, 32'h80AB_CDEF, 1'b0));
`endif

        // Reset state, during and after reset.
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("post_reset[%0d] req_ready", d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("post_reset[%0d] load_valid", d), 32'(load_valid[d]), 32'd0);
            chk($sformatf("post_reset[%0d] load_data", d), load_data[d], 32'd0);
            chk($sformatf("post_reset[%0d] sram_addr", d), 32'(sram_addr[d]), 32'd0);
        end

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < vecs.size(); i++) begin
                do_load(d, $sformatf("vec%0d_lat%0d", i, (d == 0) ? 1 : 3), vecs[i].op, vecs[i].a,
                        vecs[i].dout, vecs[i].exp_data, vecs[i].exp_mis, i % 3);
            end
        end

        do_load(1, "word_lat3_hold5", mk_op(MEM_READ, 1'b0, MEM_WORD), 32'h0000_0004,
                32'h1234_5678, 32'h1234_5678, 1'b0, 5);

        // Non-load classes must be ignored.
        for (int c = 0; c < 3; c++) begin
            logic [1:0] cls;
            cls = (c == 0) ? MEM_WRITE : ((c == 1) ? 2'b00 : 2'b11);
            req_valid[0] = 1'b1;
            mem_op[0]    = mk_op(cls, 1'b0, MEM_WORD);
            addr[0]      = 32'h0000_0010;
            for (int k = 0; k < 3; k++) begin
                #1;
                chk($sformatf("ignore_cls%0d sram_oe", c), 32'(sram_oe[0]), 32'd0);
                chk($sformatf("ignore_cls%0d load_valid", c), 32'(load_valid[0]), 32'd0);
                chk($sformatf("ignore_cls%0d req_ready", c), 32'(req_ready[0]), 32'd1);
                @(negedge clk);
            end
        end
        req_valid[0] = 1'b0;
        mem_op[0]    = 5'd0;
        repeat (3) begin
            @(negedge clk);
            chk("ignore_after load_valid", 32'(load_valid[0]), 32'd0);
        end

        // Reset while the READ_LAT=3 unit is in WAIT with a non-zero result from the previous load.
        mem_word[1]  = 32'h5555_AAAA;
        req_valid[1] = 1'b1;
        mem_op[1]    = mk_op(MEM_READ, 1'b0, MEM_WORD);
        addr[1]      = 32'h0000_0ABC;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        mem_op[1]    = 5'd0;
        @(negedge clk);
        chk("pre_reset sram_addr", 32'(sram_addr[1]), 32'h0000_0ABC);
        chk("pre_reset load_data", load_data[1], 32'h1234_5678);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("discard load_valid", 32'(load_valid[1]), 32'd0);
            chk("discard req_ready", 32'(req_ready[1]), 32'd1);
            chk("discard sram_oe", 32'(sram_oe[1]), 32'd0);
        end

        do_load(1, "after_reset_word", mk_op(MEM_READ, 1'b0, MEM_WORD), 32'h0000_0ABC,
                32'h5555_AAAA, 32'h5555_AAAA, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
